// File: rtl/demux11_dispatch.sv
// demux11_dispatch: registered 1-to-11 dispatcher, unicast by in_dest (10..15 alias lane 10) or broadcast to all lanes.
// Optional accepted-word counter (accept_count) is built when DEMUX_STATS_EN is defined.
module demux11_dispatch #(
   parameter int WIDTH = 128,
   parameter int LANES = 11
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [3:0]             in_dest,
   input  logic                   in_bcast,
   output logic [LANES-1:0]       out_valid,
   input  logic [LANES-1:0]       out_ready,
   output logic [LANES*WIDTH-1:0] out_data
`ifdef DEMUX_STATS_EN
   ,
   output logic [15:0]            accept_count
`endif
);
   logic [3:0]       lane;
   logic [LANES-1:0] lane_sel;
   logic [LANES-1:0] can_take;
   logic [LANES-1:0] load;
   logic             accept;

   always_comb begin
      lane     = (in_dest >= 4'(LANES - 1)) ? 4'(LANES - 1) : in_dest;
      lane_sel = in_bcast ? {LANES{1'b1}} : (LANES'(1) << lane);
      can_take = ~out_valid | out_ready;
      in_ready = in_bcast ? &can_take : can_take[lane];
      accept   = in_valid && in_ready;
      load     = {LANES{accept}} & lane_sel;
   end

   // A load wins over a drain on the same lane, so the lane stays full with no bubble.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_valid <= '0;
         out_data  <= '0;
      end else begin
         out_valid <= load | (out_valid & ~out_ready);
         for (int i = 0; i < LANES; i++)
            if (load[i]) out_data[i*WIDTH +: WIDTH] <= in_data;
      end
   end

`ifdef DEMUX_STATS_EN
   // A broadcast counts as one word; the counter wraps naturally at 16 bits.
   always_ff @(posedge Clk) begin
      if (Reset) accept_count <= '0;
      else if (accept) accept_count <= accept_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_demux11_dispatch.sv
// tb_demux11_dispatch: table-driven directed checks plus hand sequences for reset, streaming, broadcast and stats.
module tb_demux11_dispatch;
   localparam int W = 128;
   localparam int L = 11;

   logic           Clk = 1'b0;
   logic           Reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_data = '0;
   logic [3:0]     in_dest = '0;
   logic           in_bcast = 1'b0;
   logic [L-1:0]   out_valid;
   logic [L-1:0]   out_ready = '0;
   logic [L*W-1:0] out_data;
`ifdef DEMUX_STATS_EN
   logic [15:0]    accept_count;
`endif

   int checks = 0;
   int failures = 0;

   demux11_dispatch #(.WIDTH(W), .LANES(L)) dut (
      .Clk(Clk),
      .Reset(Reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_dest(in_dest),
      .in_bcast(in_bcast),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data)
`ifdef DEMUX_STATS_EN
      ,
      .accept_count(accept_count)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic         v;
      logic         b;
      logic [3:0]   dest;
      logic [W-1:0] data;
      logic [L-1:0] ordy;
      logic         exp_rdy;
      logic [L-1:0] exp_valid;
      int           chk_lane;
      logic [W-1:0] exp_lane;
   } vec_t;

   function automatic logic [W-1:0] lane_of(int i);
      return out_data[i*W +: W];
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive at the falling edge, let combinational in_ready settle, then sample 1ns after the rising edge.
   task automatic drive(input logic v, input logic b, input logic [3:0] dest,
                        input logic [W-1:0] data, input logic [L-1:0] ordy);
      @(negedge Clk);
      in_valid = v;
      in_bcast = b;
      in_dest = dest;
      in_data = data;
      out_ready = ordy;
      #1;
   endtask

   task automatic edge_sample();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1;
      edge_sample();
      Reset = 1'b0;
   endtask

   vec_t vecs[12];

   initial begin
      //            v     b     dest  data          ordy      rdy   valid     lane  lane data
      vecs[0]  = '{1'b1, 1'b0, 4'd3,  128'hA5,      11'h000,  1'b1, 11'h008,  3,  128'hA5};
      vecs[1]  = '{1'b1, 1'b0, 4'd14, 128'h5A,      11'h000,  1'b1, 11'h408,  10, 128'h5A};
      vecs[2]  = '{1'b1, 1'b0, 4'd3,  128'h99,      11'h000,  1'b0, 11'h408,  3,  128'hA5};
      vecs[3]  = '{1'b1, 1'b0, 4'd3,  128'h77,      11'h008,  1'b1, 11'h408,  3,  128'h77};
      vecs[4]  = '{1'b0, 1'b0, 4'd10, 128'h0,       11'h400,  1'b1, 11'h008,  10, 128'h5A};
      vecs[5]  = '{1'b1, 1'b0, 4'd15, 128'h33,      11'h000,  1'b1, 11'h408,  10, 128'h33};
      vecs[6]  = '{1'b0, 1'b0, 4'd3,  128'h0,       11'h7FF,  1'b1, 11'h000,  3,  128'h77};
      vecs[7]  = '{1'b1, 1'b0, 4'd7,  128'h1111,    11'h000,  1'b1, 11'h080,  7,  128'h1111};
      vecs[8]  = '{1'b1, 1'b1, 4'd0,  128'h1234,    11'h000,  1'b0, 11'h080,  7,  128'h1111};
      vecs[9]  = '{1'b1, 1'b1, 4'd0,  128'h1234,    11'h080,  1'b1, 11'h7FF,  0,  128'h1234};
      vecs[10] = '{1'b1, 1'b0, 4'd0,  128'hBEEF,    11'h7FF,  1'b1, 11'h001,  0,  128'hBEEF};
      vecs[11] = '{1'b1, 1'b0, 4'd5,  128'hAA,      11'h000,  1'b1, 11'h021,  5,  128'hAA};

      // Reset state
      edge_sample();
      edge_sample();
      Reset = 1'b0;
      #1;
      chk("reset_valid", W'(out_valid), '0);
      chk("reset_data_lo", lane_of(0), '0);
      chk("reset_data_hi", lane_of(10), '0);
      chk("reset_in_ready", W'(in_ready), W'(1));
`ifdef DEMUX_STATS_EN
      chk("reset_count", W'(accept_count), '0);
`endif

      // Reset mid-traffic: lanes 0, 3, 10 full, then reset with an accept pending
      drive(1'b1, 1'b0, 4'd0, 128'h10, '0);
      edge_sample();
      drive(1'b1, 1'b0, 4'd3, 128'h13, '0);
      edge_sample();
      drive(1'b1, 1'b0, 4'd12, 128'h1A, '0);
      edge_sample();
      chk("prefill_valid", W'(out_valid), W'(11'h409));
      @(negedge Clk);
      Reset = 1'b1;
      in_dest = 4'd5;
      in_data = 128'hDEAD;
      out_ready = 11'h7FF;
      edge_sample();
      Reset = 1'b0;
      chk("midreset_valid", W'(out_valid), '0);
      for (int i = 0; i < L; i++) chk($sformatf("midreset_lane%0d", i), lane_of(i), '0);
`ifdef DEMUX_STATS_EN
      chk("midreset_count", W'(accept_count), '0);
`endif

      // Table-driven unicast, alias, back-pressure, drain and broadcast vectors
      for (int k = 0; k < 12; k++) begin
         drive(vecs[k].v, vecs[k].b, vecs[k].dest, vecs[k].data, vecs[k].ordy);
         chk($sformatf("vec%0d_in_ready", k), W'(in_ready), W'(vecs[k].exp_rdy));
         edge_sample();
         chk($sformatf("vec%0d_out_valid", k), W'(out_valid), W'(vecs[k].exp_valid));
         chk($sformatf("vec%0d_lane%0d", k, vecs[k].chk_lane), lane_of(vecs[k].chk_lane), vecs[k].exp_lane);
      end

      // Broadcast over partially-full lanes with all consumers ready: every lane gets the word
      drive(1'b1, 1'b1, 4'd9, 128'hCAFE, 11'h7FF);
      chk("bcast_in_ready", W'(in_ready), W'(1));
      edge_sample();
      chk("bcast_valid", W'(out_valid), W'(11'h7FF));
      for (int i = 0; i < L; i++) chk($sformatf("bcast_lane%0d", i), lane_of(i), 128'hCAFE);

      // Empty lane keeps its last data while idle
      drive(1'b0, 1'b0, 4'd0, 128'h0, 11'h7FF);
      edge_sample();
      drive(1'b0, 1'b0, 4'd0, 128'h0, 11'h000);
      edge_sample();
      chk("idle_valid", W'(out_valid), '0);
      chk("idle_hold_lane4", lane_of(4), 128'hCAFE);

      // Streaming: 20 back-to-back words cycling through lanes 0..10
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 1'b0, 4'(k % 11), 128'h1000 + W'(k), 11'h7FF);
         chk($sformatf("stream%0d_in_ready", k), W'(in_ready), W'(1));
         edge_sample();
         chk($sformatf("stream%0d_valid", k), W'(out_valid), W'(11'(1) << (k % 11)));
         chk($sformatf("stream%0d_lane", k), lane_of(k % 11), 128'h1000 + W'(k));
      end

`ifdef DEMUX_STATS_EN
      // Stats: 65534 accepts, then unicast, broadcast, unicast across the wrap
      do_reset();
      drive(1'b1, 1'b0, 4'd0, 128'h1, 11'h7FF);
      repeat (65534) @(posedge Clk);
      #1;
      in_valid = 1'b0;
      chk("stats_preload", W'(accept_count), W'(16'hFFFE));
      drive(1'b1, 1'b0, 4'd2, 128'h2, 11'h7FF);
      edge_sample();
      chk("stats_ffff", W'(accept_count), W'(16'hFFFF));
      drive(1'b1, 1'b1, 4'd0, 128'h3, 11'h7FF);
      edge_sample();
      chk("stats_wrap", W'(accept_count), W'(16'h0000));
      drive(1'b1, 1'b0, 4'd6, 128'h4, 11'h7FF);
      edge_sample();
      chk("stats_one", W'(accept_count), W'(16'h0001));
`endif

      in_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/demux11_dispatch.md
# demux11_dispatch

Registered 1-to-11 dispatcher for the search datapath: accepts one WIDTH-bit word per cycle on a valid/ready input and delivers it to one output lane chosen by a 4-bit destination, or to all lanes in broadcast mode. It is the scatter counterpart of the 11-to-1 select mux. It distributes node/distance words from the control path to the per-lane processing registers. Each lane holds exactly one word and obeys its own valid/ready handshake.

## Interface
- WIDTH, 128, data word width in bits
- LANES, 11, number of output lanes; fixed at 11, and the dest decode below relies on it
- Clk  input  1  rising-edge clock for all state
- Reset  input  1  synchronous, active-high reset
- in_valid  input  1  source has a word
- in_ready  output  1  dispatcher accepts the word this cycle (combinational)
- in_data  input  WIDTH  word to dispatch
- in_dest  input  4  target lane; values 10..15 all select lane 10
- in_bcast  input  1  deliver the word to all 11 lanes; in_dest is ignored
- out_valid  output  11  bit i: lane i holds a word
- out_ready  input  11  bit i: lane i consumer takes the word this cycle
- out_data  output  11*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- accept_count  output  16  words accepted; present only with DEMUX_STATS_EN

## Operation
- Lane decode: d = (in_dest >= 10) ? 10 : in_dest.
- Lane i can take a word when !out_valid[i] || out_ready[i].
- Unicast (in_bcast=0): in_ready = lane d can take a word. in_valid && in_ready loads in_data into lane d and sets out_valid[d].
- Broadcast (in_bcast=1): in_ready = all 11 lanes can take a word. On acceptance, all lanes load in_data and all out_valid bits set.
- in_ready must not depend on in_valid.
- Lane drain: out_valid[i] && out_ready[i] with no new load clears out_valid[i]. If a drain and a load hit the same lane in the same cycle, the new word replaces the old one and out_valid stays 1, with no bubble.
- out_data[i] holds its value while out_valid[i]=0. Its content in that state is don't-care for consumers, but it must not change unless the lane is loaded.
- Lanes drain independently. A stalled lane blocks only unicasts to that lane and all broadcasts.
- No other state machine; per-lane state is EMPTY or FULL, tracked by out_valid[i].

## Timing
- Reset, sampled on the Clk edge: out_valid=0, all out_data=0, accept_count=0. Reset overrides any same-cycle accept or drain. A word held at reset is discarded.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N, so it is visible in cycle N+1.
- Throughput: 1 word/cycle into any lane whose consumer holds out_ready=1. Alternating lanes sustain 1 word/cycle.
- in_ready is combinational from in_dest, in_bcast, out_valid and out_ready. There is no combinational path from in_data to any output.
- in_valid=1 with in_ready=0: nothing changes and the source must hold the word.

## Configuration
- Macro DEMUX_STATS_EN.
- Defined: port accept_count is present. It increments by 1 on every accepted input, and a broadcast counts as one word. It wraps from 0xFFFF to 0x0000 and is cleared by Reset.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset mid-traffic: fill lanes 0, 3 and 10, then assert Reset for 1 cycle. Expect out_valid=0 and out_data all 0 the next cycle, and accept_count=0 if enabled.
- Unicast and alias: send 0xA5 to dest 3, then 0x5A to dest 14, with out_ready=0. Expect out_valid=0x408, lane 3 = 0xA5, lane 10 = 0x5A, and 1-cycle latency for each word.
- Back-pressure: with lane 3 full and out_ready[3]=0, present dest 3. Expect in_ready=0 and lane 3 unchanged. Then raise out_ready[3] in the same cycle as a new word 0x77. Expect in_ready=1, lane 3 = 0x77 next cycle, and out_valid[3] staying 1.
- Streaming: out_ready=all 1s, 20 back-to-back words cycling through dests 0..10. Expect in_ready=1 on every cycle, each word on the correct lane one cycle later, and nothing lost or duplicated.
- Broadcast: lane 7 full and stalled, in_bcast=1 with data 0x1234. Expect in_ready=0. Release lane 7. Expect acceptance, then out_valid=0x7FF with all lanes = 0x1234.
- Stats (DEMUX_STATS_EN): preload accept_count to 0xFFFE via 65534 accepts, then perform 3 accepts including 1 broadcast. Expect the count sequence 0xFFFF, 0x0000, 0x0001.
